// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory
// request handshake against a variable-latency memory, and loads the IF/ID
// pipeline register. A load-use stall (pc_write_i = 0) holds the PC and
// IF/ID, and an ack that arrives during a stall is parked in a one-entry
// skid buffer. A branch redirect bubbles IF/ID and discards any result
// that belongs to the old, wrong-path address.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_write_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic [31:0]       if_id_instr_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic              if_id_valid_o
);

  // FETCH: a request to pc is pending.
  // HOLD : the skid buffer is full and no request is issued.
  // DROP : a request to a stale address is in flight; its data is thrown away.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] tgt_reg;
  logic [31:0]       buf_instr_reg;
  logic [ADDR_W-1:0] buf_pc4_reg;
  logic [31:0]       if_id_instr_reg;
  logic [ADDR_W-1:0] if_id_pc4_reg;
  logic              if_id_valid_reg;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_aligned;
  logic              unused_target_bits;

  // PC increment wraps naturally at 2^ADDR_W.
  assign pc_plus4       = pc_reg + ADDR_W'(4);
  // Redirect targets are forced to a word boundary.
  assign target_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};
  // The low target bits are deliberately ignored.
  assign unused_target_bits = ^branch_target_i[1:0];

  // No request while reset is asserted, so an abandoned access is never re-issued.
  assign imem_req_o  = !rst_i && (state_reg != HOLD);
  assign imem_addr_o = {pc_reg[ADDR_W-1:2], 2'b00};

  assign if_id_instr_o = if_id_instr_reg;
  assign if_id_pc4_o   = if_id_pc4_reg;
  assign if_id_valid_o = if_id_valid_reg;

  // Fetch control, PC, redirect target, skid buffer and IF/ID register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      tgt_reg         <= '0;
      buf_instr_reg   <= '0;
      buf_pc4_reg     <= '0;
      if_id_instr_reg <= '0;
      if_id_pc4_reg   <= '0;
      if_id_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (branch_taken_i) begin
            // Redirect wins over stall: bubble now, drop any ack of the old address.
            if_id_instr_reg <= '0;
            if_id_pc4_reg   <= '0;
            if_id_valid_reg <= 1'b0;
            if (imem_ack_i) begin
              pc_reg <= target_aligned;
            end else begin
              // The old request is still outstanding; remember where to go.
              tgt_reg   <= target_aligned;
              state_reg <= DROP;
            end
          end else if (imem_ack_i) begin
            if (pc_write_i) begin
              if_id_instr_reg <= imem_data_i;
              if_id_pc4_reg   <= pc_plus4;
              if_id_valid_reg <= 1'b1;
              pc_reg          <= pc_plus4;
            end else begin
              // Stalled: park the word, stop requesting until the stall clears.
              buf_instr_reg <= imem_data_i;
              buf_pc4_reg   <= pc_plus4;
              state_reg     <= HOLD;
            end
          end else if (pc_write_i) begin
            if_id_instr_reg <= '0;
            if_id_pc4_reg   <= '0;
            if_id_valid_reg <= 1'b0;
          end
        end

        HOLD: begin
          if (branch_taken_i) begin
            // The parked word is wrong-path now.
            buf_instr_reg   <= '0;
            buf_pc4_reg     <= '0;
            if_id_instr_reg <= '0;
            if_id_pc4_reg   <= '0;
            if_id_valid_reg <= 1'b0;
            pc_reg          <= target_aligned;
            state_reg       <= FETCH;
          end else if (pc_write_i) begin
            // pc still names the parked instruction, so pc+4 equals buf_pc4.
            if_id_instr_reg <= buf_instr_reg;
            if_id_pc4_reg   <= buf_pc4_reg;
            if_id_valid_reg <= 1'b1;
            pc_reg          <= pc_plus4;
            state_reg       <= FETCH;
          end
        end

        DROP: begin
          if (branch_taken_i || pc_write_i) begin
            if_id_instr_reg <= '0;
            if_id_pc4_reg   <= '0;
            if_id_valid_reg <= 1'b0;
          end
          if (imem_ack_i) begin
            // Stale data retires here; a same-cycle redirect supersedes tgt.
            pc_reg    <= branch_taken_i ? target_aligned : tgt_reg;
            state_reg <= FETCH;
          end else if (branch_taken_i) begin
            tgt_reg <= target_aligned;
          end
        end

        default: begin
          state_reg <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit. A variable-latency memory model
// answers requests; the expected IF/ID stream is derived from the rule that
// instructions appear once, in address order, restarting at RESET_PC after
// reset and at the aligned target after each redirect. A monitor compares
// every IF/ID update against that stream.
module tb_if_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        pc_write_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;

  if_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pc_write_i     (pc_write_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_data_i    (imem_data_i),
    .if_id_instr_o  (if_id_instr_o),
    .if_id_pc4_o    (if_id_pc4_o),
    .if_id_valid_o  (if_id_valid_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int deliveries = 0;
  int phase = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- expected-stream scoreboard ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] gen_addr = RESET_PC;

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.instr  = mem_word(gen_addr);
      e.pc4    = gen_addr + 32'd4;
      exp_q.push_back(e);
      gen_addr = gen_addr + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    gen_addr = start;
    refill();
  endtask

  // Inputs as seen by each rising edge.
  logic        cap_rst, cap_br, cap_pw;
  logic [31:0] cap_tgt;
  int          cap_phase;
  bit          cap_ok = 1'b0;

  always @(posedge clk) begin
    cap_rst   <= rst_i;
    cap_br    <= branch_taken_i;
    cap_pw    <= pc_write_i;
    cap_tgt   <= branch_target_i;
    cap_phase <= phase;
    cap_ok    <= 1'b1;
  end

  // Monitor: judge the IF/ID update made by the previous rising edge.
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc4 = '0;
  logic        m_valid = 1'b0;
  bit          started = 1'b0;
  bit          seen_first = 1'b0;
  int          idle = 0;

  always @(negedge clk) begin
    exp_t e;
    if (cap_ok) begin
      if (cap_rst) begin
        check(if_id_valid_o == 1'b0, "reset_valid", {31'd0, if_id_valid_o}, 32'd0);
        check(if_id_instr_o == 32'd0, "reset_instr", if_id_instr_o, 32'd0);
        check(if_id_pc4_o == 32'd0, "reset_pc4", if_id_pc4_o, 32'd0);
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        restart(RESET_PC);
        started = 1'b1; seen_first = 1'b0; idle = 0;
      end else if (started) begin
        if (cap_br) begin
          check(if_id_valid_o == 1'b0, "branch_bubble_valid", {31'd0, if_id_valid_o}, 32'd0);
          check(if_id_instr_o == 32'd0, "branch_bubble_instr", if_id_instr_o, 32'd0);
          m_instr = '0; m_valid = 1'b0;
          restart({cap_tgt[31:2], 2'b00});
          idle++;
        end else if (cap_pw) begin
          if (cap_phase == 0 && seen_first)
            check(if_id_valid_o == 1'b1, "throughput_valid", {31'd0, if_id_valid_o}, 32'd1);
          if (if_id_valid_o) begin
            e = exp_q.pop_front();
            check(if_id_instr_o == e.instr, "deliver_instr", if_id_instr_o, e.instr);
            check(if_id_pc4_o == e.pc4, "deliver_pc4", if_id_pc4_o, e.pc4);
            $display("deliver pc4=%h instr=%h", if_id_pc4_o, if_id_instr_o);
            m_instr = e.instr; m_pc4 = e.pc4; m_valid = 1'b1;
            deliveries++; seen_first = 1'b1; idle = 0;
          end else begin
            check(if_id_instr_o == 32'd0, "bubble_instr", if_id_instr_o, 32'd0);
            m_instr = '0; m_valid = 1'b0;
            idle++;
          end
        end else begin
          check(if_id_valid_o == m_valid, "hold_valid", {31'd0, if_id_valid_o}, {31'd0, m_valid});
          check(if_id_instr_o == m_instr, "hold_instr", if_id_instr_o, m_instr);
          if (m_valid)
            check(if_id_pc4_o == m_pc4, "hold_pc4", if_id_pc4_o, m_pc4);
          idle++;
        end
        if (idle > 200) begin
          check(1'b0 == if_id_valid_o && idle <= 200, "progress_watchdog", idle, 32'd200);
          idle = 0;
        end
        refill();
      end
    end
  end

  // ---------------- stimulus and memory model ----------------
  localparam int N_CYC = 2200;

  initial begin
    bit          busy = 1'b0;
    bit          ack_prev = 1'b0;
    bit          rst_prev = 1'b1;
    bit          req_prev = 1'b0;
    bit          br_prev = 1'b0;
    bit          rose;
    int          wt = 0;
    int          lmax;
    logic [31:0] aq = '0;
    logic        r, b, p;
    logic [31:0] t;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #1;
      if (ack_prev || rst_prev) busy = 1'b0;

      t = $urandom;
      r = 1'b0; b = 1'b0; p = 1'b1; lmax = 0;
      if (cyc < 3) begin
        r = 1'b1; phase = 9;
      end else if (cyc < 23) begin
        phase = 0;                        // back-to-back acks, no stalls
      end else if (cyc < 83) begin
        phase = 1;                        // stalls against variable latency
        p = ($urandom_range(99, 0) >= 30);
        lmax = 2;
      end else if (cyc < 101) begin
        phase = 2;                        // redirect near the top of memory
        if (cyc == 83) begin
          b = 1'b1; t = 32'hFFFF_FFFB;
        end
      end else begin
        phase = 3;                        // everything mixed, incl. resets
        lmax = 3;
        r = ($urandom_range(99, 0) == 0);
        p = ($urandom_range(99, 0) >= 25);
        b = !r && !br_prev && ($urandom_range(99, 0) < 8);
        if (b) begin
          if ($urandom_range(7, 0) == 0) t = 32'hFFFF_FFF0 | {28'd0, 4'($urandom_range(15, 0))};
          else t = 32'h100 + ($urandom_range(255, 0) << 2) + $urandom_range(3, 0);
        end
      end
      if (cyc >= N_CYC - 6) begin
        r = 1'b0; b = 1'b0; p = 1'b1; phase = 4;
      end

      rst_i = r; branch_taken_i = b; branch_target_i = t; pc_write_i = p;
      #1;

      imem_ack_i  = 1'b0;
      imem_data_i = $urandom;
      rose = !req_prev;
      if (rst_i) begin
        check(imem_req_o == 1'b0, "req_in_reset", {31'd0, imem_req_o}, 32'd0);
        busy = 1'b0;
      end else begin
        if (rst_prev) begin
          check(imem_req_o == 1'b1, "req_after_reset", {31'd0, imem_req_o}, 32'd1);
          check(imem_addr_o == RESET_PC, "addr_after_reset", imem_addr_o, RESET_PC);
        end
        if (busy)
          check(imem_req_o == 1'b1, "req_held_outstanding", {31'd0, imem_req_o}, 32'd1);
        if (imem_req_o) begin
          check(imem_addr_o[1:0] == 2'b00, "addr_align", imem_addr_o, {imem_addr_o[31:2], 2'b00});
          if (busy) begin
            check(imem_addr_o == aq, "addr_stable", imem_addr_o, aq);
          end else begin
            busy = 1'b1;
            aq   = imem_addr_o;
            wt   = rose ? $urandom_range((lmax < 1) ? 1 : lmax, 1) : $urandom_range(lmax, 0);
          end
          if (wt == 0) begin
            imem_ack_i  = 1'b1;
            imem_data_i = mem_word(aq);
          end else begin
            wt--;
          end
        end else begin
          busy = 1'b0;
        end
      end

      ack_prev = imem_ack_i;
      rst_prev = rst_i;
      req_prev = imem_req_o && !rst_i;
      br_prev  = b;
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    check(deliveries > 300, "delivery_count", deliveries, 32'd301);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
